spi_flash_arbiter: RTL



---
 rtl/spi_flash_arb_pkg.sv | 18 +
 rtl/rr_arb_pick.sv | 35 +++
 rtl/spi_flash_arbiter.sv | 136 +++++++++++++
 3 files changed

// File: rtl/spi_flash_arb_pkg.sv
// rtl/spi_flash_arb_pkg.sv - shared types and helpers for the SPI flash arbiter
// Purpose: arbiter FSM state encoding and the index-width helper.
// Ports: none (package).
package spi_flash_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OWNED   = 2'd1,
        RELEASE = 2'd2,
        GAP     = 2'd3
    } arb_state_t;

    // Width of an index into n items; never less than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arb_pick.sv
// rtl/rr_arb_pick.sv - combinational round-robin picker
// Purpose: find the first set request scanning upward from start, wrapping at N.
// Ports:
//   req   in  N   request vector
//   start in  IW  index to scan from first
//   valid out 1   any request set
//   index out IW  winning index (0 when valid=0)
module rr_arb_pick #(
    parameter int N  = 2,
    parameter int IW = 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] start,
    output logic          valid,
    output logic [IW-1:0] index
);

    always_comb begin
        int j;
        j     = 0;
        valid = 1'b0;
        index = '0;
        for (int i = 0; i < N; i++) begin
            j = int'(start) + i;
            if (j >= N) begin
                j = j - N;
            end
            if (!valid && req[j]) begin
                valid = 1'b1;
                index = IW'(j);
            end
        end
    end

endmodule

// File: rtl/spi_flash_arbiter.sv
// rtl/spi_flash_arbiter.sv - round-robin owner arbiter for a shared SPI flash port
// Purpose: grants the flash pins to one of NUM_REQ SPI masters for a whole
// transaction, keeps CS high for a minimum gap between owners and optionally
// revokes ownership after HOLD_MAX cycles.
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   req/grant                    per-master level request / registered one-hot grant
//   req_cs_b/req_sck/req_mosi    per-master SPI outputs, muxed from the owner
//   req_miso                     per-master MISO, only the owner sees spi_miso
//   lock                         blocks new grants, current owner unaffected
//   spi_cs_b/spi_sck/spi_mosi    flash pins, idle outside OWNED
//   spi_miso                     flash MISO
//   busy                         high in OWNED or RELEASE
//   owner                        index of current or last owner
//   timeout_err                  one-cycle pulse on timeout revoke
module spi_flash_arbiter
    import spi_flash_arb_pkg::*;
#(
    parameter int                NUM_REQ  = 2,
    parameter int                CS_GAP   = 3,
    parameter int                HOLD_W   = 24,
    parameter logic [HOLD_W-1:0] HOLD_MAX = 24'd4_800_000,
    localparam int               IW       = idx_w(NUM_REQ)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant,
    input  logic [NUM_REQ-1:0] req_cs_b,
    input  logic [NUM_REQ-1:0] req_sck,
    input  logic [NUM_REQ-1:0] req_mosi,
    output logic [NUM_REQ-1:0] req_miso,
    input  logic               lock,
    output logic               spi_cs_b,
    output logic               spi_sck,
    output logic               spi_mosi,
    input  logic               spi_miso,
    output logic               busy,
    output logic [IW-1:0]      owner,
    output logic               timeout_err
);

    localparam int                GW        = idx_w(CS_GAP);
    localparam logic [GW-1:0]     GAP_LOAD  = GW'(CS_GAP - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_MAX - {{(HOLD_W-1){1'b0}}, 1'b1};
    localparam logic [NUM_REQ-1:0] ONE      = {{(NUM_REQ-1){1'b0}}, 1'b1};

    arb_state_t        state;
    logic [HOLD_W-1:0] hold_cnt;
    logic [GW-1:0]     gap_cnt;
    logic [IW-1:0]     rr_ptr;
    logic              pick_valid;
    logic [IW-1:0]     pick_idx;
    logic [IW-1:0]     pick_next;

    rr_arb_pick #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_pick (
        .req   (req),
        .start (rr_ptr),
        .valid (pick_valid),
        .index (pick_idx)
    );

    // Pointer kept separate from owner so that after reset requester 0 wins first.
    assign pick_next = (pick_idx == IW'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            grant       <= '0;
            owner       <= '0;
            rr_ptr      <= '0;
            hold_cnt    <= '0;
            gap_cnt     <= '1;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (!lock && pick_valid) begin
                        grant    <= ONE << pick_idx;
                        owner    <= pick_idx;
                        rr_ptr   <= pick_next;
                        hold_cnt <= '0;
                        state    <= OWNED;
                    end
                end
                OWNED: begin
                    if (hold_cnt != '1) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                    // A voluntary drop wins over a coincident timeout.
                    if (!req[owner]) begin
                        grant <= '0;
                        state <= RELEASE;
                    end else if (HOLD_MAX != '0 && hold_cnt == HOLD_LAST) begin
                        grant       <= '0;
                        timeout_err <= 1'b1;
                        state       <= RELEASE;
                    end
                end
                RELEASE: begin
                    gap_cnt <= GAP_LOAD;
                    state   <= GAP;
                end
                GAP: begin
                    if (gap_cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state == OWNED) || (state == RELEASE);

    // Owner only changes while not OWNED, so the pins never see a mux switch.
    always_comb begin
        spi_cs_b = 1'b1;
        spi_sck  = 1'b0;
        spi_mosi = 1'b0;
        req_miso = '0;
        if (state == OWNED) begin
            spi_cs_b        = req_cs_b[owner];
            spi_sck         = req_sck[owner];
            spi_mosi        = req_mosi[owner];
            req_miso[owner] = spi_miso;
        end
    end

endmodule
